// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer for an external 1-bit ALU: walks WIDTH-bit operands LSB first,
// chains the ALU carry between bits and reassembles the result word plus flags.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op_in,
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  input  logic             i_c_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_c_out,
  output logic             o_zero,
  output logic             o_alu_a,
  output logic             o_alu_b,
  output logic             o_alu_c_in,
  output logic [2:0]       o_alu_op,
  input  logic             i_alu_o,
  input  logic             i_alu_c_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_carry;
  logic             r_zacc;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_c_out;
  logic             r_zero;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // A one-bit word has no upper bits to shift down, so the ALU bit is the whole word.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = i_alu_o;
    end else begin : g_res_wn
      assign w_res_next = {i_alu_o, r_res_sr[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (w_last)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (r_state == RUN);
    o_done     = (r_state == DONE);
    o_alu_a    = 1'b0;
    o_alu_b    = 1'b0;
    o_alu_c_in = 1'b0;
    o_alu_op   = r_op;
    if (r_state == RUN) begin
      o_alu_a    = r_a_sr[0];
      o_alu_b    = r_b_sr[0];
      o_alu_c_in = r_carry;
    end
  end

  // Result flags are captured from the final ALU bit so they stay put until the next command ends.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b0;
      r_op     <= 3'b000;
      r_cnt    <= '0;
      r_result <= '0;
      r_c_out  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a_sr  <= i_a_in;
            r_b_sr  <= i_b_in;
            r_carry <= i_c_in;
            r_op    <= i_op_in;
            r_zacc  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_res_sr <= w_res_next;
          r_carry  <= i_alu_c_out;
          r_zacc   <= r_zacc & ~i_alu_o;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_res_next;
            r_c_out  <= i_alu_c_out;
            r_zero   <= r_zacc & ~i_alu_o;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_c_out  = r_c_out;
  assign o_zero   = r_zero;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: drives a 1-bit ALU model, checks every cycle against a
// timeline/arithmetic reference model, and pins directed cases with literal values.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   opIn;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic         cIn;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cOut;
  logic         zero;
  logic         aluA;
  logic         aluB;
  logic         aluCIn;
  logic [2:0]   aluOp;
  logic         aluO;
  logic         aluCOut;

  int nVec  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op_in(opIn),
    .i_a_in(aIn), .i_b_in(bIn), .i_c_in(cIn),
    .o_busy(busy), .o_done(done), .o_result(result), .o_c_out(cOut), .o_zero(zero),
    .o_alu_a(aluA), .o_alu_b(aluB), .o_alu_c_in(aluCIn), .o_alu_op(aluOp),
    .i_alu_o(aluO), .i_alu_c_out(aluCOut)
  );

  // 1-bit ALU: op 000 full adder, op 001 AND, anything else OR.
  assign aluO    = (aluOp == 3'b000) ? (aluA ^ aluB ^ aluCIn) :
                   (aluOp == 3'b001) ? (aluA & aluB) : (aluA | aluB);
  assign aluCOut = (aluOp == 3'b000) ? ((aluA & aluB) | (aluA & aluCIn) | (aluB & aluCIn)) : 1'b0;

  // Reference model: position of the current period relative to the last accepted start.
  bit           mActive = 0;
  bit           checkEn = 0;
  bit           idlePrev;
  int           mPos = 0;
  logic [W-1:0] mA, mB;
  logic [2:0]   mOp = 3'b000;
  logic         mCin;
  logic [W-1:0] eResult;
  logic         eCOut, eZero;
  logic [W:0]   mSum;

  function automatic logic carryInto(int p);
    longint mask;
    if (mOp != 3'b000) return (p == 0) ? mCin : 1'b0;
    mask = (longint'(1) << p) - 1;
    return 1'(((longint'(mA) & mask) + (longint'(mB) & mask) + longint'(mCin)) >> p);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mActive = 0;
      mPos    = 0;
      mOp     = 3'b000;
      eResult = '0;
      eCOut   = 1'b0;
      eZero   = 1'b0;
      checkEn = 1;
    end else begin
      idlePrev = !mActive || (mPos >= W + 1);
      if (idlePrev && start) begin
        mActive = 1;
        mPos    = 0;
        mA      = aIn;
        mB      = bIn;
        mOp     = opIn;
        mCin    = cIn;
      end else if (mActive) begin
        mPos++;
        if (mPos == W) begin
          if (mOp == 3'b000) begin
            mSum    = {1'b0, mA} + {1'b0, mB} + {{W{1'b0}}, mCin};
            eResult = mSum[W-1:0];
            eCOut   = mSum[W];
          end else begin
            eResult = mA & mB;
            eCOut   = 1'b0;
          end
          eZero = (eResult == '0);
        end
      end
    end
  end

  task automatic checkSig(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    bit eBusy;
    eBusy = mActive && (mPos < W);
    nVec++;
    checkSig("busy",     32'(busy),   32'(eBusy));
    checkSig("done",     32'(done),   32'(mActive && (mPos == W)));
    checkSig("result",   32'(result), 32'(eResult));
    checkSig("c_out",    32'(cOut),   32'(eCOut));
    checkSig("zero",     32'(zero),   32'(eZero));
    checkSig("alu_a",    32'(aluA),   eBusy ? 32'(mA[mPos]) : 32'd0);
    checkSig("alu_b",    32'(aluB),   eBusy ? 32'(mB[mPos]) : 32'd0);
    checkSig("alu_c_in", 32'(aluCIn), eBusy ? 32'(carryInto(mPos)) : 32'd0);
    checkSig("alu_op",   32'(aluOp),  32'(mOp));
  endtask

  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    checkSig(name, act, exp);
  endtask

  // Issues one command and follows it to its done cycle, recording per-bit ALU drive.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ci, output logic [W-1:0] seqA, output logic [W-1:0] seqCin,
                               output int busyCycles, output bit opOk);
    @(negedge clk);
    start = 1'b1; opIn = op; aIn = a; bIn = b; cIn = ci;
    @(negedge clk);
    start = 1'b0; aIn = W'($urandom); bIn = W'($urandom); cIn = 1'($urandom);
    seqA = '0; seqCin = '0; busyCycles = 0; opOk = 1;
    for (int i = 0; i < W + 8; i++) begin
      if (busy) begin
        if (busyCycles < W) begin
          seqA[busyCycles]   = aluA;
          seqCin[busyCycles] = aluCIn;
        end
        if (aluOp !== op) opOk = 0;
        busyCycles++;
      end
      if (done) break;
      @(negedge clk);
    end
    checkValue("done_reached", 32'(done), 32'd1);
  endtask

  logic [W-1:0] seqA, seqCin, resAtDone;
  int           busyCycles, doneCnt, busyCnt;
  bit           opOk, pendRstCheck;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; opIn = 3'b000; aIn = 8'h5A; bIn = 8'h33; cIn = 1'b0;
    repeat (2) @(negedge clk);
    checkValue("rst_busy",   32'(busy),   32'd0);
    checkValue("rst_done",   32'(done),   32'd0);
    checkValue("rst_result", 32'(result), 32'd0);
    checkValue("rst_alu",    32'({aluA, aluB, aluCIn, aluOp, cOut, zero}), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkValue("rst_no_run", 32'(busy), 32'd0);

    applyStimulus(3'b000, 8'h5A, 8'h33, 1'b0, seqA, seqCin, busyCycles, opOk);
    checkValue("add_busy_len", 32'(busyCycles), 32'd8);
    checkValue("add_alu_a_seq", 32'(seqA), 32'h5A);
    checkValue("add_result", 32'(result), 32'h8D);
    checkValue("add_model", 32'(eResult), 32'h8D);
    checkValue("add_flags", 32'({cOut, zero}), 32'b00);

    applyStimulus(3'b000, 8'hFF, 8'h01, 1'b0, seqA, seqCin, busyCycles, opOk);
    checkValue("wrap_result", 32'(result), 32'h00);
    checkValue("wrap_flags", 32'({cOut, zero}), 32'b11);
    checkValue("wrap_cin_seq", 32'(seqCin), 32'hFE);

    applyStimulus(3'b000, 8'h00, 8'h00, 1'b1, seqA, seqCin, busyCycles, opOk);
    checkValue("cin_result", 32'(result), 32'h01);
    checkValue("cin_flags", 32'({cOut, zero}), 32'b00);

    applyStimulus(3'b001, 8'hF0, 8'h3C, 1'b0, seqA, seqCin, busyCycles, opOk);
    checkValue("and_result", 32'(result), 32'h30);
    checkValue("and_c_out", 32'(cOut), 32'd0);
    checkValue("and_op_held", 32'(opOk), 32'd1);

    // Start re-asserted mid-run and during the done cycle must be ignored.
    @(negedge clk);
    start = 1'b1; opIn = 3'b000; aIn = 8'h5A; bIn = 8'h33; cIn = 1'b0;
    @(negedge clk);
    doneCnt = 0; busyCnt = 0; resAtDone = '0;
    for (int i = 0; i < W + 6; i++) begin
      start = 1'b0;
      if (busy) begin
        busyCnt++;
        if (busyCnt == 3) begin start = 1'b1; aIn = 8'hFF; bIn = 8'hFF; end
      end
      if (done) begin doneCnt++; resAtDone = result; start = 1'b1; end
      @(negedge clk);
    end
    start = 1'b0;
    checkValue("busy_start_dones", 32'(doneCnt), 32'd1);
    checkValue("busy_start_len", 32'(busyCnt), 32'd8);
    checkValue("busy_start_result", 32'(resAtDone), 32'h8D);

    // Reset in the fourth run cycle aborts the command without a done pulse.
    start = 1'b1; opIn = 3'b000; aIn = 8'hFF; bIn = 8'h01; cIn = 1'b0;
    @(negedge clk);
    doneCnt = 0; busyCnt = 0; pendRstCheck = 0;
    for (int i = 0; i < W + 6; i++) begin
      if (pendRstCheck) begin
        checkValue("busy_after_rst", 32'(busy), 32'd0);
        pendRstCheck = 0;
      end
      start = 1'b0;
      rst   = 1'b0;
      if (busy) begin
        busyCnt++;
        if (busyCnt == 4) begin rst = 1'b1; pendRstCheck = 1; end
      end
      if (done) doneCnt++;
      @(negedge clk);
    end
    rst = 1'b0;
    checkValue("rst_abort_dones", 32'(doneCnt), 32'd0);
    applyStimulus(3'b000, 8'h01, 8'h01, 1'b0, seqA, seqCin, busyCycles, opOk);
    checkValue("post_rst_result", 32'(result), 32'h02);
    checkValue("post_rst_flags", 32'({cOut, zero}), 32'b00);

    // Random traffic: starts at any time, occasional resets; the per-cycle model checks it all.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 3) == 0);
      opIn  = 3'($urandom_range(0, 1));
      aIn   = W'($urandom);
      bIn   = W'($urandom);
      cIn   = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
